// File: rtl/debounce_pkg.sv
// debounce_pkg: shared FSM state encoding and width helper for the key debouncer
package debounce_pkg;
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;
  function automatic int clog2(input longint v);
    int r;
    r = 0;
    while ((longint'(1) << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for one asynchronous input (clk, rst, d -> q, reset loads RESET_VAL)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= RESET_VAL;
      q  <= RESET_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/key_debounce.sv
// key_debounce: sync + debounce one raw key (clk, rst, key_in -> key_level, key_press, key_release, key_repeat pulses)
module key_debounce
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 10,
  parameter int REPEAT_CYCLES   = 5,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_repeat
);
  localparam int CW = clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = clog2(HOLD_CYCLES + REPEAT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_FIRST = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] H_WRAP = HW'(HOLD_CYCLES + REPEAT_CYCLES);
  localparam logic POL = ACTIVE_LOW != 0;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [HW-1:0] hold, hold_n, hold_inc;
  logic s2, k, level_n, press_n, release_n, repeat_n;
  sync_2ff #(.RESET_VAL(POL)) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (key_in),
    .q  (s2)
  );
  assign k = s2 ^ POL;
  assign hold_inc = hold + 1'b1;
  // hold cycles through [HOLD, HOLD+REPEAT) after the first repeat so it never overflows
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hold_n    = hold;
    level_n   = key_level;
    press_n   = 1'b0;
    release_n = 1'b0;
    repeat_n  = 1'b0;
    case (state)
      IDLE: begin
        if (k) begin
          state_n = PRESS_CHK;
          cnt_n   = CW'(1);
        end
      end
      PRESS_CHK: begin
        if (!k) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = HELD;
          cnt_n   = '0;
          level_n = 1'b1;
          press_n = 1'b1;
          hold_n  = '0;
        end else cnt_n = cnt + 1'b1;
      end
      HELD: begin
        if (!k) begin
          state_n = RELEASE_CHK;
          cnt_n   = CW'(1);
        end else if (HOLD_CYCLES > 0) begin
          hold_n   = hold_inc == H_WRAP ? H_FIRST : hold_inc;
          repeat_n = hold_inc == H_FIRST || hold_inc == H_WRAP;
        end
      end
      RELEASE_CHK: begin
        if (k) begin
          state_n = HELD;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n   = IDLE;
          cnt_n     = '0;
          level_n   = 1'b0;
          release_n = 1'b1;
        end else cnt_n = cnt + 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      hold        <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_repeat  <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      hold        <= hold_n;
      key_level   <= level_n;
      key_press   <= press_n;
      key_release <= release_n;
      key_repeat  <= repeat_n;
    end
  end
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed scenarios with a run-length reference model checked every cycle
module tb_key_debounce;
  localparam int D = 4;
  localparam int H = 10;
  localparam int R = 5;
  logic clk = 1'b0, rst = 1'b1, key_in = 1'b0, key_in_n;
  logic lvl0, prs0, rel0, rep0, lvl1, prs1, rel1, rep1;
  int total = 0, bad = 0, cyc = 0;
  logic r1, r2, k, m_lvl, m_prs, m_rel, m_rep;
  int run, h;
  int n_press = 0, n_rel = 0, n_rep = 0, press_edge = -1, press_edge1 = -1, rel_edge = -1;
  int rep_e [16];
  logic glitch_watch = 1'b0, glitch_hit = 1'b0;
  int e1, p, ea, ef, n0, r0, relb;
  assign key_in_n = ~key_in;
  always #5 clk = ~clk;
  key_debounce #(.ACTIVE_LOW(0)) dut0 (
    .clk(clk), .rst(rst), .key_in(key_in),
    .key_level(lvl0), .key_press(prs0), .key_release(rel0), .key_repeat(rep0)
  );
  key_debounce #(.ACTIVE_LOW(1)) dut1 (
    .clk(clk), .rst(rst), .key_in(key_in_n),
    .key_level(lvl1), .key_press(prs1), .key_release(rel1), .key_repeat(rep1)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at cycle %0d", n, a, e, cyc);
    end
  endtask
  // Model: level flips once D consecutive samples disagree with it; while pressed and
  // stable, repeats fire when the held count hits H, H+R, H+2R, ...
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      r1 = 1'b0; r2 = 1'b0; m_lvl = 1'b0; m_prs = 1'b0; m_rel = 1'b0; m_rep = 1'b0;
      run = 0; h = 0;
    end else begin
      k = r2; r2 = r1; r1 = key_in;
      m_prs = 1'b0; m_rel = 1'b0; m_rep = 1'b0;
      if (k != m_lvl) begin
        run++;
        if (run == D) begin
          m_lvl = k; run = 0; h = 0;
          if (k) m_prs = 1'b1; else m_rel = 1'b1;
        end
      end else begin
        if (m_lvl && run == 0) begin
          h++;
          if (H > 0 && h >= H && (h - H) % R == 0) m_rep = 1'b1;
        end
        run = 0;
      end
    end
  end
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("level", lvl0, m_lvl); chk("press", prs0, m_prs);
      chk("release", rel0, m_rel); chk("repeat", rep0, m_rep);
      chk("al_level", lvl1, m_lvl); chk("al_press", prs1, m_prs);
      chk("al_release", rel1, m_rel); chk("al_repeat", rep1, m_rep);
      if (prs0) begin n_press++; press_edge = cyc; end
      if (prs1) press_edge1 = cyc;
      if (rel0) begin n_rel++; rel_edge = cyc; end
      if (rep0) begin
        if (n_rep < 16) rep_e[n_rep] = cyc;
        n_rep++;
      end
      if (glitch_watch && (lvl0 || prs0 || rep0)) glitch_hit = 1'b1;
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_level", lvl0, 0); chk("rst_press", prs0, 0); chk("rst_al_level", lvl1, 0);
    rst = 1'b0;
    key_in = 1'b1; e1 = cyc + 1;
    repeat (8) @(negedge clk);
    chk("s1_press_cnt", n_press, 1); chk("s1_press_edge", press_edge, e1 + 5);
    chk("s1_al_press_edge", press_edge1, e1 + 5);
    chk("s1_level", lvl0, 1); chk("s1_rel_cnt", n_rel, 0);
    p = e1 + 5;
    while (cyc < p + 32) @(negedge clk);
    chk("s4_rep_cnt", n_rep, 5);
    for (int i = 0; i < 5; i++) chk("s4_rep_edge", rep_e[i], p + H + R * i);
    chk("s4_press_cnt", n_press, 1);
    r0 = n_rep;
    key_in = 1'b0; ea = cyc + 1;
    @(negedge clk); key_in = 1'b1;
    @(negedge clk); key_in = 1'b0;
    repeat (12) @(negedge clk);
    chk("s5_rel_cnt", n_rel, 1); chk("s5_rel_edge", rel_edge, ea + 7);
    chk("s5_level", lvl0, 0); chk("s5_rep_cnt", n_rep, r0);
    n0 = n_press; r0 = n_rep; glitch_watch = 1'b1;
    key_in = 1'b1;
    repeat (3) @(negedge clk);
    key_in = 1'b0;
    repeat (20) @(negedge clk);
    glitch_watch = 1'b0;
    chk("s2_press_cnt", n_press, n0); chk("s2_glitch", glitch_hit, 0); chk("s2_rep_cnt", n_rep, r0);
    key_in = 1'b1; @(negedge clk);
    key_in = 1'b0; @(negedge clk);
    key_in = 1'b1; @(negedge clk);
    key_in = 1'b0; @(negedge clk);
    key_in = 1'b1; ef = cyc + 1;
    repeat (8) @(negedge clk);
    chk("s3_press_cnt", n_press, n0 + 1); chk("s3_press_edge", press_edge, ef + 5);
    chk("s3_level", lvl0, 1);
    repeat (2) @(negedge clk);
    relb = n_rel;
    rst = 1'b1;
    @(negedge clk);
    chk("s6_level", lvl0, 0); chk("s6_release", rel0, 0); chk("s6_al_level", lvl1, 0);
    rst = 1'b0; key_in = 1'b0;
    repeat (10) @(negedge clk);
    chk("s6_rel_cnt", n_rel, relb); chk("s6_level_after", lvl0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
